// File: rtl/dcache_param_if.sv
// dcache_param_if
//   Bundles the two buses of the data cache.
//   Datapath side: halt, dmemREN, dmemWEN, dmemaddr, dmemstore in;
//                  dmemload, dhit, flushed out.
//   Memory side:   dload, dwait in; dREN, dWEN, daddr, dstore out.
//
// Handshake: a datapath request (dmemREN or dmemWEN) is held stable until the
// cycle in which dhit=1; that cycle consumes it. A memory beat (dREN or dWEN)
// holds daddr/dstore constant and completes on the first cycle with dwait=0.
//
// Modports: slave is the cache's view, master is the environment's view
// (datapath plus memory arbiter).
interface dcache_param_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_param.sv
// dcache_param
//   Two-way set-associative, write-back, write-allocate data cache with
//   SETS sets and WORDS words per block. Misses evict (bursting out a dirty
//   victim) and then fill; the held request replays as a hit. On halt every
//   dirty line is written back, then the hit count is stored at CNT_ADDR and
//   flushed is raised until reset.
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   bus        dcache_param_if.slave (datapath + memory buses)
//   dbg_state  current FSM state (IDLE=0 WB=1 FILL=2 FLUSH=3 CNT=4 DONE=5)
module dcache_param #(
    parameter int          SETS     = 8,
    parameter int          WORDS    = 2,
    parameter logic [31:0] CNT_ADDR = 32'h3100
) (
    input  logic       CLK,
    input  logic       nRST,
    dcache_param_if.slave bus,
    output logic [2:0] dbg_state
);
    localparam int IDX_W   = $clog2(SETS);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int TAG_W   = 30 - IDX_W - OFF_W;
    localparam int K_W     = (OFF_W == 0) ? 1 : OFF_W;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] SET_LAST = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT, DONE} state_t;

    state_t state_q, state_d;

    // Line storage. Only valid/dirty/lru need a reset value.
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [31:0]      data_q  [2][SETS][WORDS];
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  dirty_q [2];
    logic [SETS-1:0]  lru_q;

    logic [K_W-1:0]   k_q;        // beat index within a burst
    logic             vict_q;     // way being evicted/filled
    logic             replay_q;   // next hit is the replay of a miss
    logic [31:0]      hit_cnt_q;
    logic [IDX_W-1:0] fl_set_q;
    logic             fl_way_q;

    // Request decode; shifts keep WORDS=1 (OFF_W=0) legal.
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [K_W-1:0]   req_word;
    assign req_tag  = TAG_W'(bus.dmemaddr >> TAG_LSB);
    assign req_idx  = IDX_W'(bus.dmemaddr >> (2 + OFF_W));
    assign req_word = K_W'((bus.dmemaddr >> 2) & 32'(WORDS - 1));

    logic hit0, hit1, hit, hit_way, pick_way;
    assign hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    // First invalid way (way 0 first), otherwise the lru way.
    assign pick_way = !valid_q[0][req_idx] ? 1'b0 :
                      !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    logic req, is_write, idle_req, take_hit, take_miss, k_last, fill_we, fl_dirty, fl_last;
    assign req       = bus.dmemREN || bus.dmemWEN;
    assign is_write  = bus.dmemWEN && !bus.dmemREN;   // both high reads
    assign idle_req  = (state_q == IDLE) && !bus.halt && req;
    assign take_hit  = idle_req && hit;
    assign take_miss = idle_req && !hit;
    assign k_last    = (k_q == K_LAST);
    assign fill_we   = (state_q == FILL) && !bus.dwait;
    assign fl_dirty  = valid_q[fl_way_q][fl_set_q] && dirty_q[fl_way_q][fl_set_q];
    assign fl_last   = (fl_set_q == SET_LAST) && fl_way_q;

    assign dbg_state = state_q;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t,
                                              input logic [IDX_W-1:0] i,
                                              input logic [K_W-1:0]   k);
        logic [31:0] k_part;
        k_part = (OFF_W == 0) ? 32'd0 : (32'(k) << 2);
        return (32'(t) << TAG_LSB) | (32'(i) << (2 + OFF_W)) | k_part;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.halt)
                    state_d = FLUSH;
                else if (take_miss)
                    state_d = (valid_q[pick_way][req_idx] && dirty_q[pick_way][req_idx]) ? WB : FILL;
            end
            WB:    if (!bus.dwait && k_last) state_d = FILL;
            FILL:  if (!bus.dwait && k_last) state_d = IDLE;
            FLUSH: if (fl_last && (!fl_dirty || (!bus.dwait && k_last))) state_d = CNT;
            CNT:   if (!bus.dwait) state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        case (state_q)
            IDLE: begin
                if (take_hit) begin
                    bus.dhit     = 1'b1;
                    bus.dmemload = data_q[hit_way][req_idx][req_word];
                end
            end
            WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = line_addr(tag_q[vict_q][req_idx], req_idx, k_q);
                bus.dstore = data_q[vict_q][req_idx][k_q];
            end
            FILL: begin
                bus.dREN  = 1'b1;
                bus.daddr = line_addr(req_tag, req_idx, k_q);
            end
            FLUSH: begin
                if (fl_dirty) begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = line_addr(tag_q[fl_way_q][fl_set_q], fl_set_q, k_q);
                    bus.dstore = data_q[fl_way_q][fl_set_q][k_q];
                end
            end
            CNT: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = CNT_ADDR;
                bus.dstore = hit_cnt_q;
            end
            DONE:    bus.flushed = 1'b1;
            default: ;
        endcase
    end

    // Control state, line status bits and counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            k_q        <= '0;
            vict_q     <= 1'b0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            fl_set_q   <= '0;
            fl_way_q   <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.halt) begin
                        fl_set_q <= '0;
                        fl_way_q <= 1'b0;
                        k_q      <= '0;
                    end else if (take_hit) begin
                        lru_q[req_idx] <= ~hit_way;
                        if (is_write) dirty_q[hit_way][req_idx] <= 1'b1;
                        // The replay of a filled miss is not a counted hit.
                        if (replay_q) replay_q  <= 1'b0;
                        else          hit_cnt_q <= hit_cnt_q + 32'd1;
                    end else if (take_miss) begin
                        vict_q   <= pick_way;
                        replay_q <= 1'b1;
                        k_q      <= '0;
                    end
                end
                WB: begin
                    if (!bus.dwait) begin
                        if (k_last) begin
                            dirty_q[vict_q][req_idx] <= 1'b0;
                            k_q <= '0;
                        end else begin
                            k_q <= k_q + K_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (!bus.dwait) begin
                        if (k_last) begin
                            valid_q[vict_q][req_idx] <= 1'b1;
                            dirty_q[vict_q][req_idx] <= 1'b0;
                            lru_q[req_idx]           <= ~vict_q;
                            k_q <= '0;
                        end else begin
                            k_q <= k_q + K_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Clean lines cost one cycle; dirty lines burst then advance.
                    if (!fl_dirty || (!bus.dwait && k_last)) begin
                        if (fl_dirty) dirty_q[fl_way_q][fl_set_q] <= 1'b0;
                        k_q <= '0;
                        if (fl_way_q) begin
                            fl_way_q <= 1'b0;
                            fl_set_q <= fl_set_q + IDX_W'(1);
                        end else begin
                            fl_way_q <= 1'b1;
                        end
                    end else if (!bus.dwait) begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays
    always_ff @(posedge CLK) begin
        if (take_hit && is_write)
            data_q[hit_way][req_idx][req_word] <= bus.dmemstore;
        if (fill_we)
            data_q[vict_q][req_idx][k_q] <= bus.dload;
        if (fill_we && k_last)
            tag_q[vict_q][req_idx] <= req_tag;
    end
endmodule

// File: tb/tb_dcache_param.sv
// tb_dcache_param
//   Directed bench for dcache_param (SETS=8, WORDS=2). A reference model of
//   the cache (sets/ways/lru plus an architectural memory image) predicts
//   hit latency, read data and the ordered list of memory beats; a compare
//   process checks the DUT every cycle; a memory responder serves beats with
//   a programmable number of wait cycles.
module tb_dcache_param;
  localparam int SETS = 8;
  localparam int WORDS = 2;
  localparam int OFF_W = 1;
  localparam int IDX_W = 3;
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam logic [31:0] CNT_ADDR = 32'h3100;

  logic CLK;
  logic nRST;
  logic [2:0] dbg_state;
  dcache_param_if bus();

  dcache_param #(.SETS(SETS), .WORDS(WORDS), .CNT_ADDR(CNT_ADDR)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail = 0;
  int mem_wait = 0;
  bit chk_en = 0;
  bit cnt_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory images ----------------
  logic [31:0] mem [logic [31:0]];   // what the memory side holds
  logic [31:0] arch [logic [31:0]];  // what the datapath should read

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_pat(a);
  endfunction
  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_pat(a);
  endfunction

  // ---------------- reference model ----------------
  bit          m_valid [SETS][2];
  bit          m_dirty [SETS][2];
  int unsigned m_tag   [SETS][2];
  bit          m_lru   [SETS];
  int unsigned m_hits;
  logic [64:0] exp_q[$];   // {we, addr, data}, in expected order

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0;
      end
    end
    m_hits = 0;
  endtask

  task automatic model_req(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    int idx, way, v;
    int unsigned tag;
    logic [31:0] base;
    idx = int'((a >> (2 + OFF_W)) % SETS);
    tag = a >> TAG_LSB;
    way = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
    if (way >= 0) begin
      lat = 0;
      m_hits++;
      if (we) m_dirty[idx][way] = 1;
      m_lru[idx] = (way == 0);
    end else begin
      v = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
      lat = WORDS * (mem_wait + 1) + 1;
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        base = 32'((m_tag[idx][v] << TAG_LSB) | (idx << (2 + OFF_W)));
        for (int k = 0; k < WORDS; k++)
          exp_q.push_back({1'b1, base + 32'(4 * k), arch_rd(base + 32'(4 * k))});
        lat += WORDS * (mem_wait + 1);
      end
      base = a & ~32'(WORDS * 4 - 1);
      for (int k = 0; k < WORDS; k++)
        exp_q.push_back({1'b0, base + 32'(4 * k), 32'h0});
      m_valid[idx][v] = 1;
      m_tag[idx][v] = tag;
      m_dirty[idx][v] = we;
      m_lru[idx] = (v == 0);
    end
    if (we) arch[a & ~32'h3] = d;
  endtask

  task automatic model_flush();
    logic [31:0] base;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 2; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          base = 32'((m_tag[s][w] << TAG_LSB) | (s << (2 + OFF_W)));
          for (int k = 0; k < WORDS; k++)
            exp_q.push_back({1'b1, base + 32'(4 * k), arch_rd(base + 32'(4 * k))});
          m_dirty[s][w] = 0;
        end
    exp_q.push_back({1'b1, CNT_ADDR, 32'(m_hits)});
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.dwait = 1'b0;
    bus.dload = 32'h0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        cnt = 0; bus.dwait = 1'b0;
      end else if (bus.dREN || bus.dWEN) begin
        if (cnt < mem_wait) begin
          bus.dwait = 1'b1; cnt++;
        end else begin
          bus.dwait = 1'b0; cnt = 0;
          if (bus.dWEN) mem[bus.daddr] = bus.dstore;
        end
        bus.dload = bus.dREN ? mem_rd(bus.daddr) : 32'h0;
      end else begin
        bus.dwait = 1'b0; cnt = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [64:0] e;
    bit prev_busy;
    logic [31:0] prev_addr, prev_store;
    logic [1:0] prev_dir;
    prev_busy = 0;
    forever begin
      @(negedge CLK); #1;
      if (!chk_en || !nRST) begin
        prev_busy = 0;
      end else begin
        check("excl_ren_wen", {31'b0, bus.dREN & bus.dWEN}, 32'h0);
        check("flushed", {31'b0, bus.flushed}, {31'b0, cnt_done});
        if (prev_busy) begin
          check("hold_addr", bus.daddr, prev_addr);
          check("hold_store", bus.dstore, prev_store);
          check("hold_dir", {30'b0, bus.dREN, bus.dWEN}, {30'b0, prev_dir});
        end
        prev_busy = 0;
        if (bus.dREN || bus.dWEN) begin
          check("busy_dhit", {31'b0, bus.dhit}, 32'h0);
          check("busy_load", bus.dmemload, 32'h0);
          if (bus.dwait) begin
            prev_busy = 1;
            prev_addr = bus.daddr;
            prev_store = bus.dstore;
            prev_dir = {bus.dREN, bus.dWEN};
          end else if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got addr 0x%08h we %0d, expected no beat", bus.daddr, bus.dWEN);
          end else begin
            e = exp_q.pop_front();
            check("beat_we", {31'b0, bus.dWEN}, {31'b0, e[64]});
            check("beat_addr", bus.daddr, e[63:32]);
            if (e[64]) check("beat_data", bus.dstore, e[31:0]);
            if (e[64] && e[63:32] == CNT_ADDR) cnt_done = 1;
          end
        end
        if (bus.dhit && bus.dmemREN)
          check("dmemload", bus.dmemload, arch_rd(bus.dmemaddr & ~32'h3));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input string name, output int lat_m, output logic [31:0] rdata);
    int lat;
    model_req(we, a, d, lat_m);
    @(negedge CLK);
    bus.dmemREN = !we; bus.dmemWEN = we; bus.dmemaddr = a; bus.dmemstore = d;
    #2;
    lat = 0;
    while (!bus.dhit && lat < 200) begin
      @(negedge CLK); #2;
      lat++;
    end
    rdata = bus.dmemload;
    check({name, "_latency"}, 32'(lat), 32'(lat_m));
    @(posedge CLK); #1;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_dhit"}, {31'b0, bus.dhit}, 32'h0);
    check({name, "_flushed"}, {31'b0, bus.flushed}, 32'h0);
    check({name, "_dren"}, {31'b0, bus.dREN}, 32'h0);
    check({name, "_dwen"}, {31'b0, bus.dWEN}, 32'h0);
    check({name, "_daddr"}, bus.daddr, 32'h0);
    check({name, "_dstore"}, bus.dstore, 32'h0);
    check({name, "_dmemload"}, bus.dmemload, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lm, n;
    logic [31:0] rd;
    nRST = 1'b0;
    bus.halt = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemaddr = 32'h0; bus.dmemstore = 32'h0;
    model_reset();
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    chk_en = 1;

    // Cold read, then a hit in the same block.
    do_req(0, 32'h100, 0, "cold_rd_100", lm, rd);
    check("model_cold_latency", 32'(lm), 32'd3);
    do_req(0, 32'h104, 0, "hit_rd_104", lm, rd);
    check("model_hit_latency", 32'(lm), 32'd0);
    check("model_hits_1", m_hits, 32'd1);
    check("rd_104_value", rd, 32'h5A5A_0104);

    // Dirty eviction of the lru way in set 0.
    do_req(1, 32'h100, 32'hDEAD, "wr_100", lm, rd);
    do_req(0, 32'h300, 0, "rd_300", lm, rd);
    do_req(0, 32'h500, 0, "rd_500_evict", lm, rd);
    check("model_dirty_latency", 32'(lm), 32'd5);
    check("mem_100_written", mem_rd(32'h100), 32'hDEAD);
    do_req(0, 32'h100, 0, "rd_100_refill", lm, rd);
    check("rd_100_value", rd, 32'hDEAD);

    // lru in set 2: fill both ways, hit way 0, next miss evicts way 1.
    do_req(0, 32'h010, 0, "s2_fill0", lm, rd);
    do_req(0, 32'h050, 0, "s2_fill1", lm, rd);
    do_req(0, 32'h010, 0, "s2_hit0", lm, rd);
    do_req(0, 32'h090, 0, "s2_miss", lm, rd);
    do_req(0, 32'h010, 0, "s2_way0_kept", lm, rd);
    check("model_way0_kept", 32'(lm), 32'd0);
    do_req(0, 32'h050, 0, "s2_way1_gone", lm, rd);
    check("model_way1_gone", 32'(lm), 32'd3);

    // Slow memory: 3 wait cycles per beat.
    mem_wait = 3;
    do_req(0, 32'h218, 0, "slow_fill", lm, rd);
    check("model_slow_latency", 32'(lm), 32'd9);
    do_req(0, 32'h21C, 0, "slow_hit", lm, rd);
    mem_wait = 0;

    // Reset while a dirty victim is being written back.
    do_req(1, 32'h500, 32'h77, "wr_500", lm, rd);
    do_req(1, 32'h100, 32'h78, "wr_100b", lm, rd);
    chk_en = 0;
    mem_wait = 3;
    @(negedge CLK);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
    n = 0;
    #1;
    while (!bus.dWEN && n < 50) begin
      @(negedge CLK); #1;
      n++;
    end
    check("rst_wb_seen", {31'b0, bus.dWEN}, 32'h1);
    check("rst_wb_addr", bus.daddr, 32'h500);
    nRST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    bus.dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    exp_q.delete();
    arch = mem;
    mem_wait = 0;
    chk_en = 1;

    // Two dirty lines and five counted hits, then flush.
    do_req(1, 32'h100, 32'hA1, "post_rst_miss", lm, rd);
    check("model_post_rst_miss", 32'(lm), 32'd3);
    do_req(1, 32'h148, 32'hB2, "wr_148", lm, rd);
    do_req(0, 32'h104, 0, "fh1", lm, rd);
    do_req(0, 32'h100, 0, "fh2", lm, rd);
    check("fh2_value", rd, 32'hA1);
    do_req(1, 32'h104, 32'h1234, "fh3", lm, rd);
    do_req(0, 32'h14C, 0, "fh4", lm, rd);
    do_req(0, 32'h148, 0, "fh5", lm, rd);
    check("model_hits_5", m_hits, 32'd5);
    model_flush();
    check("model_flush_beats", 32'(exp_q.size()), 32'd5);
    check("model_flush_first", exp_q[0][63:0], 64'h0000_0100_0000_00A1);
    check("model_flush_cnt", exp_q[4][63:0], 64'h0000_3100_0000_0005);
    @(negedge CLK);
    bus.halt = 1'b1;
    n = 0;
    #2;
    while (!bus.flushed && n < 200) begin
      @(negedge CLK); #2;
      n++;
    end
    check("flushed_raised", {31'b0, bus.flushed}, 32'h1);
    repeat (5) @(negedge CLK);
    #2;
    check("flushed_held", {31'b0, bus.flushed}, 32'h1);
    check("mem_cnt_store", mem_rd(CNT_ADDR), 32'd5);
    check("mem_104_flushed", mem_rd(32'h104), 32'h1234);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_param.md
# dcache_param

Parametrised, two-way set-associative, write-back, write-allocate data cache between the datapath memory port and the memory arbiter. Set count and block size are generic. The cache evicts dirty victims with multi-word bursts. On halt it flushes every dirty line, then stores its hit count to memory at 0x3100 and raises flushed.

## Interface
- SETS, 8: number of sets, power of 2, ≥2; IDX_W = log2(SETS)
- WORDS, 2: words per block, power of 2, ≥1; OFF_W = log2(WORDS); TAG_W = 30 − IDX_W − OFF_W
- CNT_ADDR, 32'h3100: hit-count store address at end of flush
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- halt  in  1  datapath halt, level; starts flush
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- dmemaddr  in  32  byte address; [1:0] ignored
- dmemstore  in  32  write data
- dmemload  out  32  read data, valid when dhit
- dhit  out  1  request satisfied this cycle
- flushed  out  1  flush and count store complete
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  32  memory word address (low 2 bits 0)
- dstore  out  32  memory write data
- dload  in  32  memory read data, valid when dwait low
- dwait  in  1  memory busy; transfer completes on a cycle with dwait=0

## Operation
- Address split: tag = [31:2+OFF_W+IDX_W], idx = [2+OFF_W+IDX_W−1:2+OFF_W], word = [2+OFF_W−1:2].
- Per line: valid, dirty, tag, WORDS data words. Per set: one lru bit naming the way to evict.
- States: IDLE, WB, FILL, FLUSH, CNT, DONE.
- IDLE, halt=1: go to FLUSH. Halt has priority over requests.
- IDLE, request, hit in way w:
  - dhit=1 combinationally.
  - Read: dmemload = word.
  - Write: word ← dmemstore, dirty ← 1 at the clock edge.
  - lru[idx] ← ~w.
  - hit counter +1, except for a replay hit after a fill.
- If dmemREN and dmemWEN are both high, the request is treated as a read.
- IDLE, miss (no request → no action):
  - Victim selection: first invalid way, way 0 first; otherwise way lru[idx].
  - Victim dirty → WB; otherwise → FILL.
  - Set replay flag.
- WB:
  - dWEN=1, daddr = {victim tag, idx, k, 2'b00}, dstore = victim word k, for k = 0..WORDS−1.
  - k advances on each dwait=0 cycle.
  - After the last word: dirty ← 0, go to FILL.
- FILL:
  - dREN=1, daddr = {req tag, idx, k, 2'b00}.
  - On dwait=0, victim word k ← dload.
  - After the last word: tag written, valid=1, dirty=0, lru[idx] ← ~victim, go to IDLE.
  - The request replays and hits the following cycle; replay clears the flag without counting.
- The datapath holds the request stable until dhit. Address change mid-miss is illegal.
- FLUSH:
  - Scan (set, way) from (0,0) to (SETS−1,1), way-minor.
  - Clean or invalid line: skip, 1 cycle per line.
  - Dirty line: write back WORDS words as in WB, then clear dirty.
  - After the last line, go to CNT.
- CNT: dWEN=1, daddr = CNT_ADDR, dstore = hit counter; on dwait=0 go to DONE.
- DONE: flushed=1, dhit=0, no memory traffic; stays until reset.
- dREN and dWEN are never both 1.
- Hit counter is 32-bit unsigned and wraps.

## Timing
- Reset: all lines invalid/clean, lru=0, counter=0, replay=0, state IDLE. All outputs 0: dhit, flushed, dREN, dWEN, daddr, dstore, dmemload.
- Reset mid-operation aborts immediately; in-flight memory transfers are abandoned.
- Hit latency: 0 cycles (dhit in the request cycle).
- Clean miss with zero-wait memory: WORDS fill cycles, then a replay hit. dhit on cycle WORDS+1 after the request cycle.
- Dirty miss with zero-wait memory: 2·WORDS cycles, then hit.
- Each memory beat: address and data held constant while dwait=1.
- Outside IDLE: dhit=0 and dmemload=0.

## Test plan
- Read 0x100 cold with SETS=8, WORDS=2, dwait=0 → dREN at 0x100, 0x104, dhit on cycle 3; then read 0x104 → dhit same cycle, counter=1.
- Write 0x100 ← 0xDEAD, then reads of 0x300 and 0x500 (same idx 0, different tags) → the third distinct tag evicts the lru way. For the 0x100 line: dWEN 0x100 = 0xDEAD, then 0x104, then fill.
- lru check: fill ways 0 and 1 in set 2, hit way 0, miss in set 2 → way 1 evicted.
- dwait held high 3 cycles per beat during a fill → daddr and dREN stable, no dhit until the final beat, line correct.
- Two dirty lines plus 5 counted hits, halt=1 → write-back of both lines in scan order, then dWEN 0x3100 = 5, flushed=1 held.
- Assert nRST during WB → outputs 0 immediately, a subsequent read misses, counter=0.
